// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types for the I2S capture front end.
// Channel modes, receiver states and the FIFO level width helper.
package i2s_pkg;

  typedef enum logic [1:0] {
    LEFT,
    RIGHT,
    STEREO,
    MONO_MIX
  } chan_mode_e;

  typedef enum logic [1:0] {
    SYNC,
    WAIT1,
    SHIFT,
    IDLE
  } rx_state_e;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_rx_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, accepts a push on full when
// a pop happens in the same cycle.
// Ports: push/push_data/push_drop in, pop_ready/pop_valid/pop_data out,
// level = entries held.
module sync_fifo
  import i2s_pkg::*;
#(
  parameter int W     = 25,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  output logic                      push_drop,
  input  logic                      pop_ready,
  output logic                      pop_valid,
  output logic [W-1:0]              pop_data,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, pop, wr_en;

  assign pop_valid = level_q != '0;
  // Empty FIFO presents zero so outputs are clean after reset.
  assign pop_data  = pop_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;

  always_comb begin
    full      = level_q == LW'(DEPTH);
    pop       = pop_valid && pop_ready;
    wr_en     = push && (!full || pop);
    push_drop = push && !wr_en;
    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    level_d   = level_q + LW'(wr_en) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: I2S receiver with channel filtering/mono mix and sample FIFO.
// Ports: clk, reset (sync, active-high); BCLK/LRCLK/DOUT async I2S inputs;
// m_data/m_chan/m_valid/m_ready sample stream; fifo_level entries held;
// overflow/frame_err sticky flags cleared by err_clr.
module i2s_rx_fifo
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int CHAN_MODE  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           BCLK,
  input  logic                           LRCLK,
  input  logic                           DOUT,
  output logic [SAMPLE_W-1:0]            m_data,
  output logic                           m_chan,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                           overflow,
  output logic                           frame_err,
  input  logic                           err_clr
);

  localparam chan_mode_e MODE = chan_mode_e'(CHAN_MODE[1:0]);
  localparam int CW = $clog2(SLOT_W + 1);

  // Synchronisers are left unreset so a reset mid-frame does not
  // fabricate an LRCLK edge when it releases.
  logic [1:0] bclk_sync_q, lrclk_sync_q, dout_sync_q;
  logic       bclk_prev_q, lrclk_prev_q;
  logic       bclk_rise, lr_edge, lrclk_s, dout_s;

  always_ff @(posedge clk) begin
    bclk_sync_q  <= {bclk_sync_q[0], BCLK};
    lrclk_sync_q <= {lrclk_sync_q[0], LRCLK};
    dout_sync_q  <= {dout_sync_q[0], DOUT};
    bclk_prev_q  <= bclk_sync_q[1];
    lrclk_prev_q <= lrclk_sync_q[1];
  end

  assign lrclk_s   = lrclk_sync_q[1];
  assign dout_s    = dout_sync_q[1];
  assign bclk_rise = bclk_sync_q[1] && !bclk_prev_q;
  assign lr_edge   = lrclk_s ^ lrclk_prev_q;

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic                  chan_q, chan_d;
  logic                  word_vld_q, word_vld_d;
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic                  left_vld_q, left_vld_d;
  logic                  push_q, push_d;
  logic [SAMPLE_W:0]     push_data_q, push_data_d;
  logic                  ovf_q, ovf_d;
  logic                  ferr_q, ferr_d;
  logic                  new_ferr, push_drop;
  logic signed [SAMPLE_W:0] mix_sum;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    chan_d     = chan_q;
    word_vld_d = 1'b0;
    new_ferr   = 1'b0;
    unique case (state_q)
      SYNC: if (lr_edge) state_d = WAIT1;
      WAIT1: begin
        // First rise after the word-select change is the I2S delay bit.
        if (bclk_rise && !lr_edge) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (lr_edge) begin
          new_ferr = 1'b1;
          state_d  = WAIT1;
        end else if (bclk_rise) begin
          shift_d = {shift_q[SAMPLE_W-2:0], dout_s};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(SAMPLE_W - 1)) begin
            chan_d     = lrclk_s;
            word_vld_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      IDLE: if (lr_edge) state_d = WAIT1;
      default: state_d = SYNC;
    endcase
  end

  // shift_q holds the finished word while in IDLE, so it serves as the
  // capture latch for the push stage one clk later.
  always_comb begin
    mix_sum = $signed({shift_q[SAMPLE_W-1], shift_q})
            + $signed({left_q[SAMPLE_W-1], left_q});
    left_d      = left_q;
    left_vld_d  = left_vld_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (word_vld_q) begin
      unique case (MODE)
        LEFT: begin
          push_d      = !chan_q;
          push_data_d = {1'b0, shift_q};
        end
        RIGHT: begin
          push_d      = chan_q;
          push_data_d = {1'b1, shift_q};
        end
        STEREO: begin
          push_d      = 1'b1;
          push_data_d = {chan_q, shift_q};
        end
        MONO_MIX: begin
          if (!chan_q) begin
            left_d     = shift_q;
            left_vld_d = 1'b1;
          end else begin
            left_vld_d  = 1'b0;
            push_d      = left_vld_q;
            push_data_d = {1'b0, SAMPLE_W'(mix_sum >>> 1)};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ovf_d  = (ovf_q && !err_clr) || push_drop;
    ferr_d = (ferr_q && !err_clr) || new_ferr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      shift_q     <= '0;
      chan_q      <= 1'b0;
      word_vld_q  <= 1'b0;
      left_q      <= '0;
      left_vld_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      chan_q      <= chan_d;
      word_vld_q  <= word_vld_d;
      left_q      <= left_d;
      left_vld_q  <= left_vld_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  sync_fifo #(
    .W     (SAMPLE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .push_drop (push_drop),
    .pop_ready (m_ready),
    .pop_valid (m_valid),
    .pop_data  ({m_chan, m_data}),
    .level     (fifo_level)
  );

  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// tb_i2s_rx_fifo: directed bench driving one I2S bus into four receivers
// (left-only, stereo, mono-mix, stereo with a 4-deep FIFO).
module tb_i2s_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic BCLK  = 1'b1;
  logic LRCLK = 1'b1;
  logic DOUT  = 1'b0;
  logic err_clr = 1'b0;
  logic r0 = 1'b0, r2 = 1'b0, r3 = 1'b0, r4 = 1'b0;

  logic [23:0] d0, d2, d3, d4;
  logic        c0, c2, c3, c4;
  logic        v0, v2, v3, v4;
  logic [4:0]  l0, l2, l3;
  logic [2:0]  l4;
  logic        o0, o2, o3, o4;
  logic        f0, f2, f3, f4;

  int checks = 0;
  int errors = 0;
  int n;
  int max2;
  logic [24:0] q2 [$];

  i2s_rx_fifo #(.CHAN_MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .BCLK(BCLK), .LRCLK(LRCLK), .DOUT(DOUT),
    .m_data(d0), .m_chan(c0), .m_valid(v0), .m_ready(r0),
    .fifo_level(l0), .overflow(o0), .frame_err(f0), .err_clr(err_clr)
  );
  i2s_rx_fifo #(.CHAN_MODE(2)) u_m2 (
    .clk(clk), .reset(reset), .BCLK(BCLK), .LRCLK(LRCLK), .DOUT(DOUT),
    .m_data(d2), .m_chan(c2), .m_valid(v2), .m_ready(r2),
    .fifo_level(l2), .overflow(o2), .frame_err(f2), .err_clr(err_clr)
  );
  i2s_rx_fifo #(.CHAN_MODE(3)) u_m3 (
    .clk(clk), .reset(reset), .BCLK(BCLK), .LRCLK(LRCLK), .DOUT(DOUT),
    .m_data(d3), .m_chan(c3), .m_valid(v3), .m_ready(r3),
    .fifo_level(l3), .overflow(o3), .frame_err(f3), .err_clr(err_clr)
  );
  i2s_rx_fifo #(.CHAN_MODE(2), .FIFO_DEPTH(4)) u_f4 (
    .clk(clk), .reset(reset), .BCLK(BCLK), .LRCLK(LRCLK), .DOUT(DOUT),
    .m_data(d4), .m_chan(c4), .m_valid(v4), .m_ready(r4),
    .fifo_level(l4), .overflow(o4), .frame_err(f4), .err_clr(err_clr)
  );

  // Record every word the stereo receiver hands out while r2 is high.
  always @(negedge clk) begin
    if (!reset) begin
      if (v2 && r2) q2.push_back({c2, d2});
      if (int'(l2) > max2) max2 = int'(l2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One BCLK period = 8 clk; data and word select change on the fall.
  task automatic bit_cycle(input logic lr, input logic d);
    BCLK = 1'b0; LRCLK = lr; DOUT = d;
    #40;
    BCLK = 1'b1;
    #40;
  endtask

  // Slot bit k: 0 is the delay bit, 1..24 carry the word MSB first.
  task automatic send_bits(input logic lr, input logic [23:0] w,
                           input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      if (k >= 1 && k <= 24) bit_cycle(lr, w[24-k]);
      else bit_cycle(lr, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_bits(1'b0, l, 0, 32);
    send_bits(1'b1, r, 0, 32);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    chk("rst_data", d0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_level", l0, 0);
    chk("rst_chan", c0, 0);
    chk("rst_ovf", o0, 0);
    chk("rst_ferr", f0, 0);

    // Left-only capture
    do_reset();
    send_frame(24'h123456, 24'hABCDEF);
    repeat (8) @(negedge clk);
    chk("m0_level", l0, 1);
    chk("m0_valid", v0, 1);
    chk("m0_data", d0, 24'h123456);
    chk("m0_chan", c0, 0);
    r0 = 1'b1; @(negedge clk); r0 = 1'b0;
    chk("m0_empty", v0, 0);

    // Stereo streaming with consumer always ready
    do_reset();
    q2.delete();
    max2 = 0;
    r2 = 1'b1;
    send_frame(24'h000001, 24'hFFFFFF);
    repeat (8) @(negedge clk);
    r2 = 1'b0;
    chk("m2_count", q2.size(), 2);
    chk("m2_first", q2.size() > 0 ? q2[0] : 25'h0, {1'b0, 24'h000001});
    chk("m2_second", q2.size() > 1 ? q2[1] : 25'h0, {1'b1, 24'hFFFFFF});
    chk("m2_peak", max2, 1);
    chk("m2_level", l2, 0);

    // Mono mix
    do_reset();
    send_frame(24'h7FFFFF, 24'h000001);
    send_frame(24'hFFFFFF, 24'hFFFFFE);
    repeat (8) @(negedge clk);
    chk("m3_level", l3, 2);
    chk("m3_mix1", d3, 24'h400000);
    chk("m3_chan1", c3, 0);
    r3 = 1'b1; @(negedge clk); r3 = 1'b0;
    chk("m3_mix2", d3, 24'hFFFFFE);
    chk("m3_chan2", c3, 0);
    chk("m3_level1", l3, 1);
    r3 = 1'b1; @(negedge clk); r3 = 1'b0;
    chk("m3_empty", v3, 0);

    // Overflow on a 4-deep FIFO
    do_reset();
    send_frame(24'h000011, 24'h000012);
    send_frame(24'h000021, 24'h000022);
    send_frame(24'h000031, 24'h000032);
    repeat (8) @(negedge clk);
    chk("f4_level_full", l4, 4);
    chk("f4_ovf", o4, 1);
    chk("f4_head", d4, 24'h000011);
    chk("f4_head_chan", c4, 0);
    clr_pulse();
    chk("f4_ovf_clr", o4, 0);
    fork
      send_frame(24'h000041, 24'h000042);
      begin
        n = 0;
        while (u_f4.push_q !== 1'b1 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        chk("f4_push_seen", n < 2000, 1);
        r4 = 1'b1; @(negedge clk); r4 = 1'b0;
        chk("f4_pushpop_level", l4, 4);
        chk("f4_pushpop_ovf", o4, 0);
        chk("f4_pushpop_head", d4, 24'h000012);
        chk("f4_pushpop_chan", c4, 1);
      end
    join
    repeat (8) @(negedge clk);
    chk("f4_ovf_again", o4, 1);
    chk("f4_level_again", l4, 4);

    // LRCLK change after 10 bits of the left word
    do_reset();
    send_bits(1'b0, 24'h0F0F0F, 0, 11);
    send_bits(1'b1, 24'h00ABCD, 0, 32);
    repeat (8) @(negedge clk);
    chk("fe_flag", f0, 1);
    chk("fe_no_push", l0, 0);
    chk("fe_m2_level", l2, 1);
    chk("fe_m2_right", {c2, d2}, {1'b1, 24'h00ABCD});
    send_frame(24'h345678, 24'h9ABCDE);
    repeat (8) @(negedge clk);
    chk("fe_next_level", l0, 1);
    chk("fe_next_data", d0, 24'h345678);
    chk("fe_m2_level3", l2, 3);
    clr_pulse();
    chk("fe_clr", f0, 0);

    // Reset in the middle of a left slot (after 12 data bits)
    send_bits(1'b0, 24'hA5A5A5, 0, 13);
    do_reset();
    chk("mr_level", l0, 0);
    chk("mr_valid", v0, 0);
    chk("mr_data", d0, 0);
    chk("mr_m2_level", l2, 0);
    send_bits(1'b0, 24'hA5A5A5, 13, 32);
    repeat (8) @(negedge clk);
    chk("mr_no_partial", l2, 0);
    send_bits(1'b1, 24'h13579B, 0, 32);
    repeat (8) @(negedge clk);
    chk("mr_m2_first", l2, 1);
    chk("mr_m2_data", {c2, d2}, {1'b1, 24'h13579B});
    chk("mr_m0_none", l0, 0);
    send_frame(24'h2468AC, 24'h000000);
    repeat (8) @(negedge clk);
    chk("mr_m0_level", l0, 1);
    chk("mr_m0_data", d0, 24'h2468AC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx_fifo.md
Name: i2s_rx_fifo

Overview:
Parametrised I2S capture front end feeding the FFT and visualiser pipeline. Samples asynchronous BCLK/LRCLK/DOUT in the system clk domain and deserialises MSB-first samples of configurable width. Supports four channel modes and buffers samples in a FIFO with valid/ready output. Successor to the fixed 24-bit left-only capture path, adding mode selection, buffering and error reporting.

Parameters:
SAMPLE_W, 24, captured bits per sample (MSB-first, first SAMPLE_W bits of slot), range 8..32
SLOT_W, 32, BCLK periods per LRCLK half-frame, SLOT_W >= SAMPLE_W
CHAN_MODE, 0, 0 left only, 1 right only, 2 stereo interleaved, 3 mono mix (L+R)/2
FIFO_DEPTH, 16, sample FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock; BCLK must be <= clk/4
reset  in  1  synchronous, active-high
BCLK  in  1  I2S bit clock, asynchronous
LRCLK  in  1  I2S word select, asynchronous; 0 = left, 1 = right
DOUT  in  1  I2S serial data from ADC, asynchronous
m_data  out  SAMPLE_W  signed sample, two's complement
m_chan  out  1  0 left / 1 right; always 0 in CHAN_MODE 3
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accept
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: sample dropped on full FIFO
frame_err  out  1  sticky: LRCLK edge before SAMPLE_W bits captured
err_clr  in  1  clears overflow and frame_err

Behaviour:
- Clock and reset: single clock clk. Synchronous, active-high reset. All outputs are 0 on reset. The receiver enters state SYNC.
- Input synchronisation: BCLK, LRCLK and DOUT each pass through a 2-flop synchroniser. BCLK rise and LRCLK change are detected from the registered synchronised value.
- SYNC state: ignores data until the first LRCLK edge, then enters WAIT1. This also applies after reset asserted mid-frame: no partial sample is ever emitted.
- WAIT1 state: skips one BCLK rise (I2S one-bit delay), then enters SHIFT with bit count 0.
- SHIFT state:
  - On each BCLK rise, shift DOUT into the shift register.
  - When SAMPLE_W bits are captured, latch the word with its channel (LRCLK value) and enter IDLE.
  - An LRCLK edge in SHIFT sets frame_err, discards the partial word and enters WAIT1.
- IDLE state: ignores remaining slot bits. An LRCLK edge enters WAIT1.
- Channel filtering and push: the completed word pushes to the FIFO one clk after capture.
  - Mode 0: left only. Mode 1: right only. Mode 2: both, with m_chan set to the word's channel.
  - Mode 3: the left word is held. On the right word, push (L+R)>>>1, computed with SAMPLE_W+1-bit signed add and arithmetic shift (truncation toward -inf). A right word with no valid left word from the same frame is dropped; this is not an error.
- FIFO is first-word-fall-through:
  - m_valid = level != 0.
  - Pop occurs when m_valid && m_ready; the next entry appears on the following cycle.
  - Full FIFO with push: the sample is dropped and overflow set, unless a pop occurs in the same cycle, in which case the push is accepted and level is unchanged.
  - Empty FIFO with push: m_valid rises 1 cycle after the push.
- Error flags: err_clr clears both sticky flags. If err_clr and a new error occur in the same cycle, the flag stays set.
- Latency: from the BCLK rise carrying the sample LSB at the pins to m_valid, at most 5 clk (2 sync + 1 edge + 1 latch + 1 push).

Decomposition:
- Package i2s_pkg holds:
  - enum chan_mode_e: LEFT, RIGHT, STEREO, MONO_MIX
  - rx state enum: SYNC, WAIT1, SHIFT, IDLE
  - function clog2-based level width
- Sub-module sync_fifo, parametrised on width (SAMPLE_W+1) and depth, with FWFT and simultaneous push/pop when full.

Test Plan:
- Mode 0, SAMPLE_W 24, BCLK = clk/8. Send L=24'h123456, R=24'hABCDEF -> one entry: m_data 24'h123456, m_chan 0. R is not stored.
- Mode 2 with m_ready held 1. Send L=24'h000001, R=24'hFFFFFF -> two entries in order: (0x000001, chan 0) then (0xFFFFFF, chan 1). fifo_level peaks at 1.
- Mode 3. Send L=24'h7FFFFF, R=24'h000001 -> 24'h400000. Send L=24'hFFFFFF, R=24'hFFFFFE -> 24'hFFFFFE.
- Mode 2, FIFO_DEPTH 4, m_ready 0, 3 frames -> level 4 and overflow = 1. Then assert m_ready for 1 cycle in the same cycle as a push -> level stays 4 and overflow is not re-set. Pulse err_clr -> overflow = 0.
- LRCLK toggles after 10 of 24 bits -> frame_err = 1, no entry pushed. The next full slot captures correctly.
- Assert reset mid-SHIFT (bit 12) -> all outputs 0, level 0. No sample until after the next LRCLK edge plus a full slot.
